tc_program8_loader: RTL

//   Byte-stream loader that writes program images into the 8-bit program memory

---
 rtl/tc_loader_pkg.sv | 18 +
 rtl/tc_program8_loader.sv | 101 ++++++++++
 2 files changed

// File: rtl/tc_loader_pkg.sv
// Shared definitions for the program-memory byte-stream loader.
package tc_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AH,
        S_AL,
        S_LH,
        S_LL,
        S_DATA,
        S_CSUM,
        S_FIN
    } state_t;

    localparam logic [7:0] LOADER_MAGIC = 8'hA5;
    localparam int         HEADER_LEN   = 5;

endpackage

// File: rtl/tc_program8_loader.sv
// Parses MAGIC/addr/len/payload/csum frames from a valid/ready byte stream
// and drives the program memory write port, one strobe per payload byte.
module tc_program8_loader
    import tc_loader_pkg::*;
#(
    parameter logic [7:0] MAGIC      = LOADER_MAGIC,
    parameter int         ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_data,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [7:0]            mem_data,
    output logic                  mem_write,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    state_t                state;
    state_t                next_state;
    logic                  accept;
    logic [7:0]            addr_hi;
    logic [7:0]            len_hi;
    logic [7:0]            sum;
    logic [ADDR_WIDTH-1:0] addr;
    logic [15:0]           remaining;

    assign accept = in_valid && in_ready;

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (accept && in_data == MAGIC) next_state = S_AH;
            S_AH:   if (accept) next_state = S_AL;
            S_AL:   if (accept) next_state = S_LH;
            S_LH:   if (accept) next_state = S_LL;
            S_LL:   if (accept) next_state = ({len_hi, in_data} != 16'd0) ? S_DATA : S_CSUM;
            S_DATA: if (accept && remaining == 16'd1) next_state = S_CSUM;
            S_CSUM: if (accept) next_state = S_FIN;
            S_FIN:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // in_ready and busy are registered from next_state so they line up with
    // the state they describe; FIN is the only non-reset cycle that stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            in_ready    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_data    <= '0;
            addr_hi     <= '0;
            len_hi      <= '0;
            sum         <= '0;
            addr        <= '0;
            remaining   <= '0;
        end else begin
            state     <= next_state;
            in_ready  <= (next_state != S_FIN);
            busy      <= (next_state != S_IDLE);
            done      <= 1'b0;
            mem_write <= 1'b0;
            if (accept) begin
                case (state)
                    S_IDLE: begin
                        if (in_data == MAGIC) begin
                            error <= 1'b0;
                            sum   <= '0;
                        end
                    end
                    S_AH: addr_hi <= in_data;
                    S_AL: addr <= ADDR_WIDTH'({addr_hi, in_data});
                    S_LH: len_hi <= in_data;
                    S_LL: remaining <= {len_hi, in_data};
                    S_DATA: begin
                        mem_address <= addr;
                        mem_data    <= in_data;
                        mem_write   <= 1'b1;
                        addr        <= addr + ADDR_WIDTH'(1);
                        sum         <= sum + in_data;
                        remaining   <= remaining - 16'd1;
                    end
                    S_CSUM: begin
                        if (in_data == sum) done  <= 1'b1;
                        else                error <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
